// File: rtl/captura_jogada_pkg.sv
// Shared definitions for captura_jogada: FSM state codes (also the db_estado
// display codes) and the one-hot key check.
package captura_jogada_pkg;

  typedef enum logic [3:0] {
    ESPERA   = 4'h0,
    FILTRA   = 4'h1,
    REGISTRA = 4'h2,
    SOLTA    = 4'h3
  } estado_t;

  function automatic logic one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for the four raw key lines; async active-high reset to 0.
module sincronizador_2ff (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] sync_p0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 4'b0000;
      q       <= 4'b0000;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/captura_jogada.sv
// Key capture: synchronize, debounce and validate a one-hot press, then latch it
// with a one-cycle strobe. Debounce filtering is enabled by CAPTURA_JOGADA_DEBOUNCE_EN.
module captura_jogada #(
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zera,
  input  logic [3:0] chaves,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       db_tem_jogada,
  output logic [3:0] db_estado
);
  import captura_jogada_pkg::*;

  if (DEBOUNCE_CICLOS < 2) begin : g_param_check
    $error("DEBOUNCE_CICLOS must be at least 2");
  end

  logic [3:0] s_chaves;
  estado_t    estado;
  logic       entra_registra;
  logic [3:0] valor;

  sincronizador_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (chaves),
    .q     (s_chaves)
  );

`ifdef CAPTURA_JOGADA_DEBOUNCE_EN
  localparam int              CNT_W   = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       cand;

  always_comb begin
    entra_registra = (estado == FILTRA) && (s_chaves == cand) && (cnt == CNT_MAX);
    valor          = cand;
  end
`else
  always_comb begin
    entra_registra = (estado == ESPERA) && (s_chaves != 4'b0000);
    valor          = s_chaves;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado          <= ESPERA;
      jogada          <= 4'b0000;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
`ifdef CAPTURA_JOGADA_DEBOUNCE_EN
      cnt             <= '0;
      cand            <= 4'b0000;
`endif
    end else begin
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;

      case (estado)
`ifdef CAPTURA_JOGADA_DEBOUNCE_EN
        ESPERA: begin
          cnt <= '0;
          if (s_chaves != 4'b0000) begin
            cand   <= s_chaves;
            estado <= FILTRA;
          end
        end
        FILTRA: begin
          if (s_chaves == 4'b0000) begin
            cnt    <= '0;
            estado <= ESPERA;
          end else if (s_chaves != cand) begin
            cand <= s_chaves;
            cnt  <= '0;
          end else if (cnt == CNT_MAX) begin
            estado <= REGISTRA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REGISTRA: begin
          cnt    <= '0;
          estado <= SOLTA;
        end
        // Only an unbroken run of released samples lets the FSM rearm.
        SOLTA: begin
          if (s_chaves != 4'b0000) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            estado <= ESPERA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`else
        ESPERA: begin
          if (entra_registra) estado <= REGISTRA;
        end
        REGISTRA: estado <= SOLTA;
        SOLTA: begin
          if (s_chaves == 4'b0000) estado <= ESPERA;
        end
`endif
        default: estado <= ESPERA;
      endcase

      // Strobes are registered on the edge that enters REGISTRA.
      if (entra_registra) begin
        if (!one_hot4(valor)) begin
          jogada_invalida <= 1'b1;
        end else if (!zera) begin
          jogada       <= valor;
          jogada_feita <= 1'b1;
        end
      end

      if (zera) jogada <= 4'b0000;
    end
  end

  assign db_estado     = estado;
  assign db_tem_jogada = (estado != ESPERA);

endmodule
